cpu_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined CPU.
- Generates sequential fetch addresses from a PC register.
- Drives a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions with their PC in a DEPTH-entry prefetch queue.
- Presents them to decode through a valid/ready handshake; a redirect input (branch/jump) flushes the front end and restarts fetch at a new target.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_fetch_unit_fetch_queue.sv | 60 ++++++
 rtl/cpu_fetch_unit.sv | 97 +++++++++
 tb/tb_cpu_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and the prefetch-queue entry type for the CPU front end.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam logic [ADDR_W_DEF-1:0] RESET_ADDR_DEF = '0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_unit_fetch_queue.sv
// Synchronous FIFO of fetched {pc, instruction} entries with a priority flush.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  entry_t           i_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output entry_t           o_head
);

    // Sized to the pointer range so DEPTH=1 still has a legal 1-bit index.
    entry_t           r_mem [2**PTR_W];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (w_do_pop || (r_count != CNT_W'(DEPTH)));

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_flush && w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // The issue logic upstream must never let a push hit a full queue.
    always_ff @(posedge i_clk) begin
        if (!i_flush) assert (w_do_push || !i_push);
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, one outstanding memory read,
// prefetch queue and redirect flush toward decode.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] ADDR_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [ADDR_W-1:0] o_instruction_address,
    output logic              o_instruction_read,
    input  logic [DATA_W-1:0] i_instruction_data,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_target,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_instruction,
    output logic [ADDR_W-1:0] o_pc
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_inflight;
    logic              r_inflight;
    logic              r_kill;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_flush;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [OCC_W-1:0]  w_occupancy;
    entry_t            w_entry;
    entry_t            w_head;

    assign w_valid = !w_empty && !i_reset;
    assign w_pop   = w_valid && i_ready && !i_redirect;
    assign w_push  = r_inflight && !r_kill;
    assign w_flush = i_reset || i_redirect;

    // Counting the pop that happens this cycle keeps a full queue streaming.
    assign w_occupancy = {1'b0, w_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue     = !i_reset && !i_redirect && (w_occupancy < OCC_W'(DEPTH));

    assign w_entry = '{pc: r_pc_inflight, instr: i_instruction_data};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_ADDR;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= r_inflight && i_redirect;
            if (i_redirect)   r_pc <= i_redirect_target;
            else if (w_issue) r_pc <= r_pc + ADDR_STEP;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_issue) r_pc_inflight <= r_pc;
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .i_clk   (i_clk),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_entry),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign o_instruction_address = r_pc;
    assign o_instruction_read    = w_issue;
    assign o_valid               = w_valid;
    assign o_instruction         = w_head.instr;
    assign o_pc                  = w_head.pc;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: directed timing steps on three configurations plus
// a randomized run against a queue-level reference model.
module tb_cpu_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic          rst;
    logic [DW-1:0] key;

    // Default configuration
    logic          redir_a, ready_a, rd_a, valid_a;
    logic [AW-1:0] tgt_a, addr_a, pc_a;
    logic [DW-1:0] data_a, instr_a;
    // RESET_ADDR = 16'hFFFE
    logic          redir_b, ready_b, rd_b, valid_b;
    logic [AW-1:0] tgt_b, addr_b, pc_b;
    logic [DW-1:0] data_b, instr_b;
    // DEPTH = 1
    logic          redir_c, ready_c, rd_c, valid_c;
    logic [AW-1:0] tgt_c, addr_c, pc_c;
    logic [DW-1:0] data_c, instr_c;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {16'h0000, a} ^ key;
    endfunction

    cpu_fetch_unit dut_a (
        .i_clk(clk), .i_reset(rst),
        .o_instruction_address(addr_a), .o_instruction_read(rd_a),
        .i_instruction_data(data_a),
        .i_redirect(redir_a), .i_redirect_target(tgt_a),
        .o_valid(valid_a), .i_ready(ready_a),
        .o_instruction(instr_a), .o_pc(pc_a)
    );

    cpu_fetch_unit #(.RESET_ADDR(16'hFFFE)) dut_b (
        .i_clk(clk), .i_reset(rst),
        .o_instruction_address(addr_b), .o_instruction_read(rd_b),
        .i_instruction_data(data_b),
        .i_redirect(redir_b), .i_redirect_target(tgt_b),
        .o_valid(valid_b), .i_ready(ready_b),
        .o_instruction(instr_b), .o_pc(pc_b)
    );

    cpu_fetch_unit #(.DEPTH(1)) dut_c (
        .i_clk(clk), .i_reset(rst),
        .o_instruction_address(addr_c), .o_instruction_read(rd_c),
        .i_instruction_data(data_c),
        .i_redirect(redir_c), .i_redirect_target(tgt_c),
        .o_valid(valid_c), .i_ready(ready_c),
        .o_instruction(instr_c), .o_pc(pc_c)
    );

    // 1-cycle synchronous memories; garbage on cycles with no request.
    always @(posedge clk) data_a <= rd_a ? word_of(addr_a) : $urandom;
    always @(posedge clk) data_b <= rd_b ? word_of(addr_b) : $urandom;
    always @(posedge clk) data_c <= rd_c ? word_of(addr_c) : $urandom;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [AW-1:0] mq[$];
    logic [AW-1:0] mpc, pend_pc, t16;
    int            pend, sz, pops, waited;
    logic          exp_valid, exp_pop, exp_read, found;
    logic [AW-1:0] exp_c;

    initial begin
        rst = 1'b1; key = 32'hA5A5_0000;
        redir_a = 0; tgt_a = '0; ready_a = 0;
        redir_b = 0; tgt_b = '0; ready_b = 1;
        redir_c = 0; tgt_c = '0; ready_c = 0;

        // Reset state
        next_cycle(); mid();
        chk("rst_read", 32'(rd_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'h0000_FFFE);

        // Streaming with ready high; RESET_ADDR wrap on dut_b
        next_cycle(); rst = 0; ready_a = 1;
        for (int k = 0; k < 10; k++) begin
            mid();
            chk("t1_read", 32'(rd_a), 32'd1);
            chk("t1_addr", 32'(addr_a), 32'(k));
            if (k < 4) begin
                t16 = 16'hFFFE + 16'(k);
                chk("t4_read_b", 32'(rd_b), 32'd1);
                chk("t4_addr_b", 32'(addr_b), 32'(t16));
            end
            if (k >= 2) begin
                chk("t1_valid", 32'(valid_a), 32'd1);
                chk("t1_pc", 32'(pc_a), 32'(k - 2));
                chk("t1_instr", instr_a, word_of(16'(k - 2)));
            end else begin
                chk("t1_valid_early", 32'(valid_a), 32'd0);
            end
            next_cycle();
        end

        // Back-pressure fills the queue, then drains in order
        rst = 1; ready_a = 0; mid();
        chk("t2_rst_valid", 32'(valid_a), 32'd0);
        chk("t2_rst_read", 32'(rd_a), 32'd0);
        next_cycle(); rst = 0;
        for (int k = 0; k < 7; k++) begin
            mid();
            if (k < 4) begin
                chk("t2_read", 32'(rd_a), 32'd1);
                chk("t2_addr", 32'(addr_a), 32'(k));
            end else begin
                chk("t2_stall", 32'(rd_a), 32'd0);
                chk("t2_hold_valid", 32'(valid_a), 32'd1);
                chk("t2_hold_pc", 32'(pc_a), 32'd0);
            end
            next_cycle();
        end
        ready_a = 1; mid();
        chk("t2_lookahead_read", 32'(rd_a), 32'd1);
        chk("t2_lookahead_addr", 32'(addr_a), 32'd4);
        chk("t2_drain_pc", 32'(pc_a), 32'd0);
        for (int k = 1; k < 4; k++) begin
            next_cycle(); mid();
            chk("t2_drain_valid", 32'(valid_a), 32'd1);
            chk("t2_drain_pc", 32'(pc_a), 32'(k));
        end

        // Redirect with two entries queued and one read in flight
        next_cycle(); rst = 1; mid();
        next_cycle(); rst = 0; ready_a = 0;
        for (int k = 0; k < 3; k++) begin mid(); next_cycle(); end
        redir_a = 1; tgt_a = 16'h0100; ready_a = 1; mid();
        chk("t3_r_read", 32'(rd_a), 32'd0);
        chk("t3_r_pc", 32'(pc_a), 32'd0);
        next_cycle(); redir_a = 0; mid();
        chk("t3_r1_valid", 32'(valid_a), 32'd0);
        chk("t3_r1_read", 32'(rd_a), 32'd1);
        chk("t3_r1_addr", 32'(addr_a), 32'h0100);
        next_cycle(); mid();
        chk("t3_r2_valid", 32'(valid_a), 32'd0);
        chk("t3_r2_addr", 32'(addr_a), 32'h0101);
        for (int k = 0; k < 6; k++) begin
            next_cycle(); mid();
            chk("t3_valid", 32'(valid_a), 32'd1);
            chk("t3_pc", 32'(pc_a), 32'(16'h0100 + k));
            chk("t3_instr", instr_a, word_of(16'(16'h0100 + k)));
        end

        // Reset with three queued and one read in flight
        next_cycle(); rst = 1; mid();
        next_cycle(); rst = 0; ready_a = 0;
        for (int k = 0; k < 4; k++) begin mid(); next_cycle(); end
        rst = 1; mid();
        chk("t5_rst_valid", 32'(valid_a), 32'd0);
        chk("t5_rst_read", 32'(rd_a), 32'd0);
        next_cycle(); rst = 0; ready_a = 1; mid();
        chk("t5_c1_valid", 32'(valid_a), 32'd0);
        chk("t5_c1_read", 32'(rd_a), 32'd1);
        chk("t5_c1_addr", 32'(addr_a), 32'd0);
        next_cycle(); mid();
        chk("t5_c2_valid", 32'(valid_a), 32'd0);
        next_cycle(); mid();
        chk("t5_c3_valid", 32'(valid_a), 32'd1);
        chk("t5_c3_pc", 32'(pc_a), 32'd0);
        chk("t5_c3_instr", instr_a, word_of(16'h0000));

        // Randomized traffic against the queue-level model
        next_cycle(); rst = 1; key = $urandom; mid();
        next_cycle(); rst = 0;
        mq.delete(); pend = 0; mpc = '0; pend_pc = '0;
        for (int n = 0; n < 400; n++) begin
            ready_a = ($urandom_range(0, 3) != 0);
            redir_a = ($urandom_range(0, 11) == 0);
            tgt_a   = 16'($urandom);
            mid();
            sz        = mq.size();
            exp_valid = (sz != 0);
            exp_pop   = exp_valid && ready_a && !redir_a;
            exp_read  = !redir_a && ((sz + pend - (exp_pop ? 1 : 0)) < 4);
            chk("rnd_valid", 32'(valid_a), 32'(exp_valid));
            chk("rnd_read", 32'(rd_a), 32'(exp_read));
            chk("rnd_addr", 32'(addr_a), 32'(mpc));
            if (exp_valid) begin
                chk("rnd_pc", 32'(pc_a), 32'(mq[0]));
                chk("rnd_instr", instr_a, word_of(mq[0]));
            end
            if (redir_a) begin
                mq.delete();
                mpc = tgt_a;
            end else begin
                if (exp_pop) void'(mq.pop_front());
                if (pend != 0) mq.push_back(pend_pc);
            end
            pend_pc = mpc;
            if (exp_read) mpc = mpc + 16'd1;
            pend = exp_read ? 1 : 0;
            next_cycle();
        end
        redir_a = 0;

        // DEPTH=1 with ready toggling every cycle
        rst = 1; mid();
        next_cycle(); rst = 0; exp_c = '0; pops = 0;
        for (int k = 0; k < 40; k++) begin
            ready_c = ((k % 2) == 0);
            mid();
            if (valid_c && ready_c) begin
                chk("d1_pc", 32'(pc_c), 32'(exp_c));
                chk("d1_instr", instr_c, word_of(exp_c));
                exp_c = exp_c + 16'd1;
                pops++;
            end
            next_cycle();
        end
        chk("d1_pops", 32'(pops), 32'd19);

        // Redirect and pop in the same cycle
        ready_c = 1; redir_c = 1; tgt_c = 16'h0200; mid();
        chk("d1_r_valid", 32'(valid_c), 32'd1);
        chk("d1_r_read", 32'(rd_c), 32'd0);
        next_cycle(); redir_c = 0; mid();
        chk("d1_r1_addr", 32'(addr_c), 32'h0200);
        found = 0; waited = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (k > 0) begin next_cycle(); mid(); end
            if (valid_c) begin
                found  = 1;
                waited = k;
                chk("d1_redir_pc", 32'(pc_c), 32'h0200);
            end
        end
        chk("d1_redir_seen", 32'(found), 32'd1);
        chk("d1_redir_latency", 32'(waited), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
